// File: rtl/smm1_sched_pkg.sv
// Shared definitions for the SMM1 sequencing controller and the SMM1 wrappers.
package smm_pkg;

  localparam int DATAWIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // A bus carries a full 4x4 matrix of DATAWIDTH-wide elements.
  function automatic int bus_width(input int dw);
    return 16 * dw;
  endfunction

endpackage

// File: rtl/smm1_sched_if.sv
// Job request / result response channels between the job queue and smm1_sched.
interface smm1_sched_if
  import smm_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int TAGW      = 4
);
  localparam int BUSWIDTH = bus_width(DATAWIDTH);

  logic                req_valid;
  logic                req_ready;
  logic [BUSWIDTH-1:0] req_a;
  logic [BUSWIDTH-1:0] req_b;
  logic                req_sel;
  logic [TAGW-1:0]     req_tag;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [BUSWIDTH-1:0] rsp_c;
  logic [TAGW-1:0]     rsp_tag;
  logic                rsp_sel;

  // Job-queue side: offers jobs, consumes results.
  modport master (
    output req_valid, req_a, req_b, req_sel, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_c, rsp_tag, rsp_sel
  );

  // Controller side.
  modport slave (
    input  req_valid, req_a, req_b, req_sel, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_c, rsp_tag, rsp_sel
  );

endinterface

// File: rtl/smm1_sched.sv
// Sequences one job at a time through a single SMM1 instance: load pulse,
// fixed-latency wait, result capture and a held valid/ready response.
module smm1_sched
  import smm_pkg::*;
#(
  parameter  int DATAWIDTH = DATAWIDTH_DEF,
  parameter  int TAGW      = 4,
  parameter  int LATENCY   = 6,
  localparam int BUSWIDTH  = bus_width(DATAWIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  smm1_sched_if.slave         bus,
  output logic [BUSWIDTH-1:0] smm_a,
  output logic [BUSWIDTH-1:0] smm_b,
  output logic                smm_load,
  output logic                smm_sel,
  input  logic [BUSWIDTH-1:0] smm_c,
  output logic                busy,
  output logic [15:0]         done_count
);

  localparam int             CNTW     = $clog2(LATENCY + 1);
  localparam logic [CNTW-1:0] CNT_INIT = CNTW'(LATENCY - 1);

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [TAGW-1:0] tag_q;

  // req_ready is low while rst is asserted and high on the first cycle after.
  assign bus.req_ready = (state == IDLE) && !rst;
  assign busy          = (state != IDLE);

  // smm_a/smm_b/smm_sel double as the operand register: SMM1's sel is
  // combinational through its pipeline, so they must not move until RESP ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      tag_q         <= '0;
      smm_a         <= '0;
      smm_b         <= '0;
      smm_sel       <= 1'b0;
      smm_load      <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_c     <= '0;
      bus.rsp_tag   <= '0;
      bus.rsp_sel   <= 1'b0;
      done_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            smm_a    <= bus.req_a;
            smm_b    <= bus.req_b;
            smm_sel  <= bus.req_sel;
            tag_q    <= bus.req_tag;
            smm_load <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          smm_load <= 1'b0;
          cnt      <= CNT_INIT;
          state    <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            bus.rsp_c     <= smm_c;
            bus.rsp_tag   <= tag_q;
            bus.rsp_sel   <= smm_sel;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            done_count    <= done_count + 16'd1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smm1_sched.sv
// Randomized self-checking bench for smm1_sched against a cycle-level job model
// and a fixed-delay SMM1 stand-in that returns smm_a ^ smm_b.
module tb_smm1_sched;
  import smm_pkg::*;

  localparam int DW  = 32;
  localparam int TW  = 4;
  localparam int LAT = 6;
  localparam int BW  = 16 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] smm_a, smm_b, smm_c;
  logic          smm_load, smm_sel, busy;
  logic [15:0]   done_count;

  always #5 clk = ~clk;

  smm1_sched_if #(.DATAWIDTH(DW), .TAGW(TW)) bus ();

  smm1_sched #(.DATAWIDTH(DW), .TAGW(TW), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .smm_a      (smm_a),
    .smm_b      (smm_b),
    .smm_load   (smm_load),
    .smm_sel    (smm_sel),
    .smm_c      (smm_c),
    .busy       (busy),
    .done_count (done_count)
  );

  // SMM1 stand-in: result of the operands sampled at the load edge appears
  // LAT cycles after the load cycle.
  logic [BW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= smm_a ^ smm_b;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign smm_c = pipe[LAT-1];

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  // Reference model state: at most one job in flight.
  bit            inflight = 1'b0;
  int            acc_cyc  = 0;
  logic [BW-1:0] j_a, j_b;
  logic [TW-1:0] j_tag;
  logic          j_sel;
  logic [15:0]   exp_done = '0;
  bit            post_rst = 1'b0;
  bit            accepted = 1'b0;
  bit            b2b      = 1'b0;
  int            n_acc    = 0;
  int            prev_acc = 0;
  logic [TW-1:0] seen_tags [$];

  // Inputs for the next cycle, applied at the falling edge.
  logic          nx_rst    = 1'b1;
  logic          nx_valid  = 1'b0;
  logic [BW-1:0] nx_a      = '0;
  logic [BW-1:0] nx_b      = '0;
  logic          nx_sel    = 1'b0;
  logic [TW-1:0] nx_tag    = '0;
  logic          nx_rready = 1'b1;
  bit            rand_rdy  = 1'b0;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [BW-1:0] rnd_mat();
    logic [BW-1:0] m;
    for (int i = 0; i < 16; i++) m[i*DW +: DW] = $urandom;
    return m;
  endfunction

  task automatic monitor();
    bit e_rdy, e_rv, hs, acc;
    e_rdy = !rst && !inflight;
    chk("req_ready", bus.req_ready, e_rdy);
    if (rst) begin
      inflight = 1'b0;
      exp_done = '0;
      post_rst = 1'b1;
    end else begin
      e_rv = inflight && (cyc >= acc_cyc + 2 + LAT);
      chk("busy", busy, inflight);
      chk("smm_load", smm_load, inflight && (cyc == acc_cyc + 1));
      chk("rsp_valid", bus.rsp_valid, e_rv);
      chk("done_count", done_count, exp_done);
      if (inflight && cyc > acc_cyc) begin
        chk("smm_a", smm_a, j_a);
        chk("smm_b", smm_b, j_b);
        chk("smm_sel", smm_sel, j_sel);
      end
      if (e_rv) begin
        chk("rsp_c", bus.rsp_c, j_a ^ j_b);
        chk("rsp_tag", bus.rsp_tag, j_tag);
        chk("rsp_sel", bus.rsp_sel, j_sel);
      end
      if (post_rst && !inflight) begin
        chk("rst_smm_a", smm_a, '0);
        chk("rst_smm_b", smm_b, '0);
        chk("rst_rsp_c", bus.rsp_c, '0);
        chk("rst_rsp_tag", bus.rsp_tag, '0);
        chk("rst_rsp_sel", bus.rsp_sel, '0);
        chk("rst_smm_sel", smm_sel, '0);
      end
      hs  = e_rv && bus.rsp_ready;
      acc = e_rdy && bus.req_valid;
      if (hs) begin
        inflight = 1'b0;
        exp_done = exp_done + 16'd1;
        seen_tags.push_back(j_tag);
      end
      if (acc) begin
        if (b2b && n_acc > 0) chk("acc_gap", cyc - prev_acc, LAT + 3);
        prev_acc = cyc;
        n_acc++;
        inflight = 1'b1;
        acc_cyc  = cyc;
        j_a      = bus.req_a;
        j_b      = bus.req_b;
        j_tag    = bus.req_tag;
        j_sel    = bus.req_sel;
        post_rst = 1'b0;
        accepted = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rand_rdy) nx_rready = 1'($urandom_range(0, 1));
    rst           = nx_rst;
    bus.req_valid = nx_valid;
    bus.req_a     = nx_a;
    bus.req_b     = nx_b;
    bus.req_sel   = nx_sel;
    bus.req_tag   = nx_tag;
    bus.rsp_ready = nx_rready;
    #1;
    cyc++;
    monitor();
  endtask

  task automatic send(input logic [BW-1:0] a, input logic [BW-1:0] b,
                      input logic sel, input logic [TW-1:0] tag);
    int k;
    nx_valid = 1'b1; nx_a = a; nx_b = b; nx_sel = sel; nx_tag = tag;
    accepted = 1'b0;
    for (k = 0; k < 300 && !accepted; k++) step();
    if (!accepted) chk("accept_timeout", accepted, 1'b1);
    nx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    for (k = 0; k < budget && inflight; k++) step();
    if (inflight) chk("idle_timeout", inflight, 1'b0);
  endtask

  initial begin
    logic [15:0] d0;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0;
    bus.req_sel = 1'b0; bus.req_tag = '0; bus.rsp_ready = 1'b0;

    repeat (3) step();
    nx_rst = 1'b0;
    repeat (3) step();
    chk("reset_req_ready", bus.req_ready, 1'b1);
    chk("reset_done", done_count, 16'd0);

    send({16{32'h1}}, {16{32'h3}}, 1'b0, 4'd5);
    wait_idle(40);
    step();
    chk("t1_done", done_count, 16'd1);
    chk("t1_rsp_c", bus.rsp_c, {16{32'h2}});
    chk("t1_rsp_tag", bus.rsp_tag, 4'd5);

    b2b = 1'b1; n_acc = 0; seen_tags.delete();
    d0 = done_count;
    for (int t = 1; t <= 3; t++) send(rnd_mat(), rnd_mat(), 1'b0, TW'(t));
    wait_idle(40);
    step();
    b2b = 1'b0;
    chk("t2_ntags", seen_tags.size(), 3);
    for (int i = 0; i < seen_tags.size(); i++) chk("t2_order", seen_tags[i], i + 1);
    chk("t2_done", done_count, d0 + 16'd3);

    nx_rready = 1'b0;
    send(rnd_mat(), rnd_mat(), 1'b1, 4'd9);
    repeat (2 + LAT) step();
    chk("t3_rsp_valid", bus.rsp_valid, 1'b1);
    repeat (20) step();
    chk("t3_hold_rdy", bus.req_ready, 1'b0);
    nx_rready = 1'b1;
    step();
    step();
    chk("t3_idle_busy", busy, 1'b0);
    chk("t3_idle_rdy", bus.req_ready, 1'b1);

    send(rnd_mat(), rnd_mat(), 1'b0, 4'd7);
    repeat (3) step();
    nx_rst = 1'b1;
    step();
    nx_rst = 1'b0;
    step();
    chk("t4_load", smm_load, 1'b0);
    chk("t4_valid", bus.rsp_valid, 1'b0);
    chk("t4_busy", busy, 1'b0);
    chk("t4_done", done_count, 16'd0);
    chk("t4_smm_a", smm_a, '0);
    repeat (12) step();
    send(rnd_mat(), rnd_mat(), 1'b0, 4'd3);
    wait_idle(40);
    step();
    chk("t4_after", done_count, 16'd1);

    send(rnd_mat(), rnd_mat(), 1'b1, 4'hA);
    repeat (2 + LAT) step();
    chk("t5_smm_sel", smm_sel, 1'b1);
    chk("t5_rsp_sel", bus.rsp_sel, 1'b1);
    chk("t5_rsp_tag", bus.rsp_tag, 4'hA);
    wait_idle(40);
    step();

    rand_rdy = 1'b1;
    for (int j = 0; j < 25; j++) begin
      repeat ($urandom_range(0, 3)) step();
      send(rnd_mat(), rnd_mat(), 1'($urandom_range(0, 1)), TW'($urandom));
    end
    wait_idle(400);
    rand_rdy = 1'b0;
    nx_rready = 1'b1;
    step();

    force dut.done_count = 16'hFFFF;
    #1;
    release dut.done_count;
    exp_done = 16'hFFFF;
    step();
    send(rnd_mat(), rnd_mat(), 1'b0, 4'd1);
    wait_idle(40);
    step();
    chk("t6_wrap", done_count, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
